mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, giving the busy duration of mult/multu in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, giving the busy duration of div/divu in cycles.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request from E stage, qualified by op.
REQ-006 SHALL have port op  input  3  operation: MULT, MULTU, DIV, DIVU, MTHI, MTLO; other codes are NOP.
REQ-007 SHALL have port a  input  32  rs operand; also the source for MTHI/MTLO.
REQ-008 SHALL have port b  input  32  rt operand.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight; the stall controller stalls HI/LO users on start|busy.
REQ-010 SHALL have port hi  output  32  architectural HI register, read by mfhi.
REQ-011 SHALL have port lo  output  32  architectural LO register, read by mflo.

Function
REQ-012 SHALL, on an edge with start=1, busy=0 and op in {MULT,MULTU,DIV,DIVU}, latch op, a and b, load the counter with MULT_CYCLES or DIV_CYCLES, and enter state RUN.
REQ-013 SHALL use two states: IDLE (busy=0) and RUN (busy=1). busy is a registered output, never combinational from start.
REQ-014 SHALL, in RUN, decrement the counter each edge. On the edge where the counter reaches 1, SHALL write the result to hi/lo and return to IDLE.
- For start sampled at edge E0, busy is high from E0 to E0+N exactly (N cycles).
- New hi/lo are visible from the same cycle busy falls.
REQ-015 SHALL leave hi/lo unchanged while RUN is active.
REQ-016 SHALL compute MULT as the signed 64-bit product of a and b, and MULTU as the unsigned product; hi receives product[63:32] and lo receives product[31:0].
REQ-017 SHALL compute DIV as a signed divide with the quotient truncated toward zero: lo=quotient; hi=remainder, which carries the sign of the dividend.
REQ-018 SHALL compute DIVU as an unsigned divide: lo=quotient, hi=remainder.
REQ-019 SHALL handle division by zero (b=0 for DIV or DIVU) by running the full DIV_CYCLES and then leaving hi/lo unchanged.
REQ-020 SHALL produce lo=0x80000000, hi=0 for DIV with a=0x80000000 and b=0xFFFFFFFF, without error.
REQ-021 SHALL, on an edge with start=1, busy=0 and op=MTHI/MTLO, write a to hi/lo at that edge, with no busy assertion.
REQ-022 SHALL ignore start while busy=1, whatever the op; operands and the counter are unaffected.
REQ-023 SHALL treat start=1 with a NOP op code as no action.

Reset
REQ-024 SHALL, on reset=1 at an edge, set busy=0, hi=0, lo=0, counter=0 and state=IDLE. This includes abandoning an in-flight operation without writing its result.
REQ-025 SHALL give reset priority over start on the same edge.

Structure
REQ-026 SHALL take the op encodings (3-bit constants) and the MULT_CYCLES/DIV_CYCLES defaults from the shared CPU package also used by the decoder and the stall controller.
REQ-027 SHALL be a single module with no sub-module. The product and quotient/remainder are computed from the latched operands and registered at completion.

Verification
REQ-028 SHALL cover MULT: a=0xFFFFFFFE (-2), b=3, start at edge 0 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-029 SHALL cover MULTU: a=0xFFFFFFFF, b=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-030 SHALL cover DIV: a=-7 (0xFFFFFFF9), b=2 -> busy for 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also cover DIVU with a=7, b=2 -> lo=3, hi=1.
REQ-031 SHALL cover start during busy: DIV starts, then MULT pulses at cycle 3 -> MULT ignored; busy stays high for 10 cycles total, and only the DIV result is written.
REQ-032 SHALL cover MTHI/MTLO: MTHI with a=0x12345678 -> hi=0x12345678 at the next edge, busy remains 0. Also cover DIV with b=0 -> 10 busy cycles, hi/lo unchanged.
REQ-033 SHALL cover reset mid-operation: MULT in flight, reset at cycle 2 -> next cycle busy=0, hi=lo=0, and no later write occurs.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared CPU definitions: HI/LO unit op encodings, default latencies and FSM state type.
// Imported by the decoder, the stall controller and mult_div_unit.
package mult_div_unit_pkg;

  localparam logic [2:0] OpNop   = 3'd0;
  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  localparam int unsigned MultCyclesDefault = 5;
  localparam int unsigned DivCyclesDefault  = 10;

  typedef enum logic {
    StIdle,
    StRun
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Operands are latched at start; the result is registered when the countdown completes.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDefault,
  parameter int unsigned DIV_CYCLES  = DivCyclesDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);

  md_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_u_divisor, div_s_divisor;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;
  logic        div_zero, div_ovf;

  always_comb begin
    div_zero = (b_q == 32'd0);
    div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hffff_ffff);
    // Dividing by 1 instead of -1 yields exactly 0x80000000 rem 0 for the overflow case.
    div_u_divisor = div_zero ? 32'd1 : b_q;
    div_s_divisor = (div_zero || div_ovf) ? 32'd1 : b_q;
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    quo_s  = $signed(a_q) / $signed(div_s_divisor);
    rem_s  = $signed(a_q) % $signed(div_s_divisor);
    quo_u  = a_q / div_u_divisor;
    rem_u  = a_q % div_u_divisor;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          case (op)
            OpMult, OpMultu: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = MultLoad;
              state_d = StRun;
            end
            OpDiv, OpDivu: begin
              op_d    = op;
              a_d     = a;
              b_d     = b;
              cnt_d   = DivLoad;
              state_d = StRun;
            end
            OpMthi:  hi_d = a;
            OpMtlo:  lo_d = a;
            default: ;
          endcase
        end
      end
      StRun: begin
        if (cnt_q <= CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          case (op_q)
            OpMult: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
            end
            OpMultu: begin
              hi_d = prod_u[63:32];
              lo_d = prod_u[31:0];
            end
            OpDiv: begin
              if (!div_zero) begin
                hi_d = rem_s;
                lo_d = quo_s;
              end
            end
            OpDivu: begin
              if (!div_zero) begin
                hi_d = rem_u;
                lo_d = quo_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpNop;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == StRun);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: expected HI/LO/latency are queued at issue and
// checked when busy falls.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = OpNop;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi, lo;

  int   vectors = 0;
  int   errors  = 0;
  exp_t sb[$];
  logic [31:0] hi_m = '0, lo_m = '0;

  mult_div_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic done in 64-bit longint, independently of the RTL datapath.
  task automatic model(input logic [2:0] mop, input logic [31:0] ma, input logic [31:0] mb,
                       output logic [31:0] rhi, output logic [31:0] rlo);
    longint p, q, r;
    logic [63:0] pu;
    rhi = hi_m;
    rlo = lo_m;
    case (mop)
      OpMult: begin
        p = longint'($signed(ma)) * longint'($signed(mb));
        rhi = p[63:32];
        rlo = p[31:0];
      end
      OpMultu: begin
        pu = {32'd0, ma} * {32'd0, mb};
        rhi = pu[63:32];
        rlo = pu[31:0];
      end
      OpDiv: if (mb != 0) begin
        q = longint'($signed(ma)) / longint'($signed(mb));
        r = longint'($signed(ma)) % longint'($signed(mb));
        rhi = r[31:0];
        rlo = q[31:0];
      end
      OpDivu: if (mb != 0) begin
        q = longint'({32'd0, ma}) / longint'({32'd0, mb});
        r = longint'({32'd0, ma}) % longint'({32'd0, mb});
        rhi = r[31:0];
        rlo = q[31:0];
      end
      default: ;
    endcase
  endtask

  // Issue one long op; intr >= 0 pulses a MULT start at that busy cycle (must be ignored).
  task automatic run_op(input string tag, input logic [2:0] rop, input logic [31:0] ra,
                        input logic [31:0] rb, input logic [31:0] ehi, input logic [31:0] elo,
                        input int intr);
    exp_t e;
    exp_t got;
    int   cnt;
    e.hi = ehi;
    e.lo = elo;
    e.cycles = (rop == OpDiv || rop == OpDivu) ? DC : MC;
    sb.push_back(e);
    start = 1'b1; op = rop; a = ra; b = rb;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      if (cnt == 1) begin
        check({tag, "_hi_hold"}, hi, hi_m);
        check({tag, "_lo_hold"}, lo, lo_m);
      end
      start = (cnt == intr);
      op = OpMult; a = 32'h0000_0003; b = 32'h0000_0005;
      cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    got = sb.pop_front();
    check({tag, "_busy_cycles"}, 32'(cnt), 32'(got.cycles));
    check({tag, "_hi"}, hi, got.hi);
    check({tag, "_lo"}, lo, got.lo);
    hi_m = got.hi;
    lo_m = got.lo;
  endtask

  task automatic run_model(input string tag, input logic [2:0] rop, input logic [31:0] ra,
                           input logic [31:0] rb);
    logic [31:0] ehi, elo;
    model(rop, ra, rb, ehi, elo);
    run_op(tag, rop, ra, rb, ehi, elo, -1);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("mult_neg", OpMult, 32'hffff_fffe, 32'd3, 32'hffff_ffff, 32'hffff_fffa, -1);
    run_op("multu", OpMultu, 32'hffff_ffff, 32'd2, 32'h0000_0001, 32'hffff_fffe, -1);
    run_op("div_neg", OpDiv, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 32'hffff_fffd, -1);
    run_op("divu", OpDivu, 32'd7, 32'd2, 32'd1, 32'd3, -1);
    run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hffff_ffff, 32'd0, 32'h8000_0000, -1);
    run_model("mult_mix", OpMult, 32'h8000_0000, 32'h7fff_ffff);
    run_model("multu_big", OpMultu, 32'hdead_beef, 32'hcafe_f00d);
    run_model("div_pos_neg", OpDiv, 32'd100, 32'hffff_fff9);
    run_model("divu_big", OpDivu, 32'hffff_fff0, 32'd13);

    // Start during busy must not disturb the DIV in flight.
    run_op("busy_ignore", OpDiv, 32'd100, 32'd7, 32'd2, 32'd14, 2);

    // Divide by zero: full latency, HI/LO keep their previous values.
    run_op("div_zero", OpDiv, 32'h1234_5678, 32'd0, hi_m, lo_m, -1);
    run_op("divu_zero", OpDivu, 32'h1234_5678, 32'd0, hi_m, lo_m, -1);

    start = 1'b1; op = OpMthi; a = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, lo_m);
    hi_m = 32'h1234_5678;
    start = 1'b1; op = OpMtlo; a = 32'h9abc_def0;
    @(negedge clk);
    start = 1'b0;
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_lo", lo, 32'h9abc_def0);
    check("mtlo_hi", hi, hi_m);
    lo_m = 32'h9abc_def0;

    for (int i = 0; i < 2; i++) begin
      start = 1'b1; op = (i == 0) ? OpNop : 3'd7; a = 32'h5555_aaaa; b = 32'd9;
      @(negedge clk);
      start = 1'b0;
      check("nop_busy", {31'd0, busy}, 32'd0);
      check("nop_hi", hi, hi_m);
      check("nop_lo", lo, lo_m);
    end

    // Reset two cycles into a MULT abandons it.
    start = 1'b1; op = OpMult; a = 32'd1000; b = 32'd1000;
    @(negedge clk);
    start = 1'b0;
    check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi", hi, 32'd0);
    check("rst_mid_lo", lo, 32'd0);
    repeat (8) @(negedge clk);
    check("rst_late_hi", hi, 32'd0);
    check("rst_late_lo", lo, 32'd0);
    check("rst_late_busy", {31'd0, busy}, 32'd0);
    hi_m = '0;
    lo_m = '0;

    // Reset wins over a simultaneous MTHI.
    reset = 1'b1; start = 1'b1; op = OpMthi; a = 32'hffff_0000;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("rst_prio_hi", hi, 32'd0);
    check("rst_prio_busy", {31'd0, busy}, 32'd0);

    run_model("post_rst_mult", OpMult, 32'hffff_fff9, 32'hffff_fff9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
